// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
// Holds the FSM state encoding and the BCD digit constants used by the
// top-level sequencer and the one-digit adder.
package bcd_serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_serial_adder_if.sv
// Operand/result bundle of the serial BCD adder.
// master: request side (start, sub, x, y) driven, result side observed.
// slave:  adder side; samples the request, drives s/carry/busy/done/invalid.
interface bcd_serial_adder_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  sub;
  logic [4*DIGITS-1:0]   x;
  logic [4*DIGITS-1:0]   y;
  logic [4*DIGITS-1:0]   s;
  logic                  carry;
  logic                  busy;
  logic                  done;
  logic                  invalid;

  modport master (
    output start, sub, x, y,
    input  s, carry, busy, done, invalid
  );

  modport slave (
    input  start, sub, x, y,
    output s, carry, busy, done, invalid
  );
endinterface

// File: rtl/bcd_serial_adder_digit_add.sv
// One-digit BCD add/subtract step, purely combinational.
// Latency: 0 cycles. Backpressure: none (no state).
// Ports: a_i/b_i digits, cin_i carry in, sub_i selects a + (9-b) + cin;
//        s_o result digit, cout_o decimal carry, bad_o set when a or b > 9.
module bcd_digit_add
  import bcd_serial_adder_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       cin_i,
  input  logic       sub_i,
  output logic [3:0] s_o,
  output logic       cout_o,
  output logic       bad_o
);

  logic [3:0] b_eff;
  logic [4:0] t;

  always_comb begin
    bad_o  = (a_i > BCD_MAX) || (b_i > BCD_MAX);
    // Nine's complement of b; together with carry-in = sub at the first
    // digit this forms the ten's complement of the whole operand.
    b_eff  = sub_i ? (BCD_MAX - b_i) : b_i;
    t      = {1'b0, a_i} + {1'b0, b_eff} + {4'd0, cin_i};
    if (t > {1'b0, BCD_MAX}) begin
      s_o    = t[3:0] + BCD_ADJ;
      cout_o = 1'b1;
    end else begin
      s_o    = t[3:0];
      cout_o = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first.
// Latency: START at edge n -> BUSY cycles n+1..n+DIGITS -> DONE pulse at n+DIGITS+1.
// Backpressure: START is ignored while BUSY; accepted in IDLE and in the DONE cycle.
// Ports: clk_i, rst_n_i (async active-low); bus (slave) carries start/sub/x/y in
//        and s/carry/busy/done/invalid out; s/carry/invalid hold between DONEs.
module bcd_serial_adder
  import bcd_serial_adder_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  bcd_serial_adder_if.slave   bus
);

  localparam int W     = 4 * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e           state_q, state_d;
  logic [W-1:0]     x_q, x_d;
  logic [W-1:0]     y_q, y_d;
  logic [W-1:0]     part_q, part_d;
  logic [W-1:0]     s_q, s_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             sub_q, sub_d;
  logic             c_q, c_d;
  logic             bad_q, bad_d;
  logic             carry_q, carry_d;
  logic             invalid_q, invalid_d;

  logic [3:0]       dig_s;
  logic             dig_cout;
  logic             dig_bad;
  logic [W-1:0]     dig_ext;

  // Operands are shifted right each RUN cycle, so the current digit is
  // always in bits [3:0].
  bcd_digit_add u_digit (
    .a_i    (x_q[3:0]),
    .b_i    (y_q[3:0]),
    .cin_i  (c_q),
    .sub_i  (sub_q),
    .s_o    (dig_s),
    .cout_o (dig_cout),
    .bad_o  (dig_bad)
  );

  // New digit enters at the top of the partial register; after DIGITS
  // shifts digit 0 has reached bits [3:0].
  assign dig_ext = W'(dig_s) << (4 * (DIGITS - 1));

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    part_d    = part_q;
    s_d       = s_q;
    idx_d     = idx_q;
    sub_d     = sub_q;
    c_d       = c_q;
    bad_d     = bad_q;
    carry_d   = carry_q;
    invalid_d = invalid_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          x_d     = bus.x;
          y_d     = bus.y;
          sub_d   = bus.sub;
          c_d     = bus.sub;
          idx_d   = '0;
          bad_d   = 1'b0;
          part_d  = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        x_d    = x_q >> 4;
        y_d    = y_q >> 4;
        c_d    = dig_cout;
        bad_d  = bad_q | dig_bad;
        part_d = (part_q >> 4) | dig_ext;
        if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
          idx_d   = '0;
          if (bad_q | dig_bad) begin
            s_d       = '0;
            carry_d   = 1'b0;
            invalid_d = 1'b1;
          end else begin
            s_d       = (part_q >> 4) | dig_ext;
            carry_d   = dig_cout;
            invalid_d = 1'b0;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      x_q       <= '0;
      y_q       <= '0;
      part_q    <= '0;
      s_q       <= '0;
      idx_q     <= '0;
      sub_q     <= 1'b0;
      c_q       <= 1'b0;
      bad_q     <= 1'b0;
      carry_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      part_q    <= part_d;
      s_q       <= s_d;
      idx_q     <= idx_d;
      sub_q     <= sub_d;
      c_q       <= c_d;
      bad_q     <= bad_d;
      carry_q   <= carry_d;
      invalid_q <= invalid_d;
    end
  end

  assign bus.s       = s_q;
  assign bus.carry   = carry_q;
  assign bus.invalid = invalid_q;
  assign bus.busy    = (state_q == ST_RUN);
  assign bus.done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed bench for bcd_serial_adder: a 4-digit and a 1-digit instance
// share clock and reset; expected results are hand-computed constants.
module tb_bcd_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  bcd_serial_adder_if #(.DIGITS(4)) b4 ();
  bcd_serial_adder_if #(.DIGITS(1)) b1 ();

  bcd_serial_adder #(.DIGITS(4)) dut4 (.clk_i(clk), .rst_n_i(rst_n), .bus(b4));
  bcd_serial_adder #(.DIGITS(1)) dut1 (.clk_i(clk), .rst_n_i(rst_n), .bus(b1));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulse start on the 4-digit instance; returns in cycle n+1.
  task automatic launch4(input logic [15:0] x, input logic [15:0] y, input logic sub);
    b4.x = x; b4.y = y; b4.sub = sub; b4.start = 1'b1;
    tick;
    b4.start = 1'b0;
  endtask

  task automatic wait_done4(input string tag);
    int n = 0;
    while (b4.done !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk({tag, "_done_seen"}, 16'(b4.done), 16'd1);
  endtask

  task automatic run_op4(input string tag, input logic [15:0] x, input logic [15:0] y,
                         input logic sub, input logic [15:0] es, input logic ec,
                         input logic ei);
    launch4(x, y, sub);
    wait_done4(tag);
    chk({tag, "_s"}, b4.s, es);
    chk({tag, "_carry"}, 16'(b4.carry), 16'(ec));
    chk({tag, "_invalid"}, 16'(b4.invalid), 16'(ei));
    tick;
  endtask

  initial begin
    b4.start = 1'b0; b4.sub = 1'b0; b4.x = '0; b4.y = '0;
    b1.start = 1'b0; b1.sub = 1'b0; b1.x = '0; b1.y = '0;

    // Reset state
    #12;
    chk("rst_s", b4.s, 16'h0000);
    chk("rst_carry", 16'(b4.carry), 16'd0);
    chk("rst_busy", 16'(b4.busy), 16'd0);
    chk("rst_done", 16'(b4.done), 16'd0);
    chk("rst_invalid", 16'(b4.invalid), 16'd0);
    chk("rst1_s", 16'(b1.s), 16'd0);
    rst_n = 1'b1;
    tick;

    // 1: exact latency, 0099 + 0001
    launch4(16'h0099, 16'h0001, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("t1_busy_c%0d", i), 16'(b4.busy), 16'd1);
      chk($sformatf("t1_nodone_c%0d", i), 16'(b4.done), 16'd0);
      tick;
    end
    chk("t1_done_c5", 16'(b4.done), 16'd1);
    chk("t1_busy_c5", 16'(b4.busy), 16'd0);
    chk("t1_s", b4.s, 16'h0100);
    chk("t1_carry", 16'(b4.carry), 16'd0);
    chk("t1_invalid", 16'(b4.invalid), 16'd0);
    tick;
    chk("t1_done_pulse", 16'(b4.done), 16'd0);
    chk("t1_s_hold", b4.s, 16'h0100);

    // 2: carry out cases
    run_op4("t2a", 16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op4("t2b", 16'h4567, 16'h5678, 1'b0, 16'h0245, 1'b1, 1'b0);

    // 3: subtraction, with and without borrow
    run_op4("t3a", 16'h0100, 16'h0001, 1'b1, 16'h0099, 1'b1, 1'b0);
    run_op4("t3b", 16'h0001, 16'h0002, 1'b1, 16'h9999, 1'b0, 1'b0);

    // 4: invalid digit, then recovery
    run_op4("t4a", 16'h00A3, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b1);
    chk("t4a_invalid_hold", 16'(b4.invalid), 16'd1);
    run_op4("t4b", 16'h0003, 16'h0005, 1'b0, 16'h0008, 1'b0, 1'b0);

    // 5a: START during BUSY is ignored
    launch4(16'h1234, 16'h1111, 1'b0);
    b4.x = 16'h5555; b4.y = 16'h4444; b4.sub = 1'b1; b4.start = 1'b1;
    tick;
    b4.start = 1'b0;
    wait_done4("t5a");
    chk("t5a_s", b4.s, 16'h2345);
    chk("t5a_carry", 16'(b4.carry), 16'd0);
    tick;

    // 5b: reset in the second RUN cycle aborts with no DONE
    launch4(16'h1111, 16'h2222, 1'b0);
    tick;
    rst_n = 1'b0;
    #1;
    chk("t5b_busy", 16'(b4.busy), 16'd0);
    chk("t5b_done", 16'(b4.done), 16'd0);
    chk("t5b_s", b4.s, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk($sformatf("t5b_nodone_%0d", i), 16'(b4.done), 16'd0);
    end
    rst_n = 1'b1;
    tick;
    chk("t5b_idle_after", 16'(b4.busy), 16'd0);

    // 5c: START held across DONE gives back-to-back operation
    b4.x = 16'h0011; b4.y = 16'h0022; b4.sub = 1'b0; b4.start = 1'b1;
    tick;
    wait_done4("t5c_first");
    chk("t5c_first_s", b4.s, 16'h0033);
    b4.x = 16'h0100; b4.y = 16'h0200;
    tick;
    b4.start = 1'b0;
    chk("t5c_no_idle", 16'(b4.busy), 16'd1);
    wait_done4("t5c_second");
    chk("t5c_second_s", b4.s, 16'h0300);
    tick;

    // 6: single-digit instance
    b1.x = 4'h9; b1.y = 4'h9; b1.sub = 1'b0; b1.start = 1'b1;
    tick;
    b1.start = 1'b0;
    chk("t6a_busy_c1", 16'(b1.busy), 16'd1);
    tick;
    chk("t6a_done_c2", 16'(b1.done), 16'd1);
    chk("t6a_s", 16'(b1.s), 16'h0008);
    chk("t6a_carry", 16'(b1.carry), 16'd1);
    tick;
    b1.x = 4'h3; b1.y = 4'h7; b1.sub = 1'b1; b1.start = 1'b1;
    tick;
    b1.start = 1'b0;
    tick;
    chk("t6b_done", 16'(b1.done), 16'd1);
    chk("t6b_s", 16'(b1.s), 16'h0006);
    chk("t6b_carry", 16'(b1.carry), 16'd0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bcd_serial_adder.md
Name: bcd_serial_adder

Overview:
Parametrised multi-digit BCD adder/subtractor, the sequential successor to the single-digit combinational BCD adder.
- Processes one BCD digit per clock, least-significant digit first, with a START/BUSY/DONE handshake.
- Adds SUB mode using ten's complement and detects invalid (non-BCD) input digits.
- Sits between operand registers and the 7-segment/display path in the calculator datapath.

Parameters:
DIGITS, 4, number of BCD digits per operand (>=1); operand width is 4*DIGITS.

Ports:
CLK  input  1  system clock, rising edge.
RST_N  input  1  asynchronous active-low reset.
START  input  1  request to begin an operation; sampled only when accepting.
SUB  input  1  0 = X+Y, 1 = X-Y; sampled with START.
X  input  4*DIGITS  packed BCD operand, digit 0 = bits [3:0]; sampled with START.
Y  input  4*DIGITS  packed BCD operand, same packing; sampled with START.
S  output  4*DIGITS  registered result; changes only when entering DONE.
CARRY  output  1  add: decimal carry out; sub: 1 = no borrow (X>=Y).
BUSY  output  1  high while in RUN.
DONE  output  1  one-cycle pulse; S, CARRY and INVALID are valid from this cycle.
INVALID  output  1  some digit of X or Y was >9; valid with DONE and held until the next DONE.

Behaviour:
- Reset (RST_N low, asynchronous):
  - state=IDLE.
  - S=0, CARRY=0, BUSY=0, DONE=0, INVALID=0.
  - Internal operand, partial-sum and index registers are cleared.
  - Reset mid-operation aborts the operation with no DONE.
- States:
  - IDLE: START=1 latches X, Y and SUB, sets index=0, sets carry_in=SUB, and goes to RUN.
  - RUN: BUSY=1. Each cycle computes digit[index]. After digit DIGITS-1 it goes to DONE; otherwise index increments.
  - DONE: DONE=1 for exactly one cycle, then returns to IDLE. START is also accepted in DONE, going directly to RUN for back-to-back operation.
- START is ignored while in RUN; latched operands are unaffected.
- Digit step (per RUN cycle):
  - y' = SUB ? (9 - Yi) : Yi.
  - t = Xi + y' + c, 5 bits wide.
  - If t>9: digit = (t+6)[3:0], c=1. Else: digit = t[3:0], c=0.
  - The result digit goes into an internal shift/partial register.
- Invalid digits:
  - Any latched Xi or Yi >9 sets an internal sticky flag during RUN.
  - On entry to DONE with the flag set: S=0, CARRY=0, INVALID=1.
  - Otherwise on entry to DONE: S=partial result, CARRY=final c, INVALID=0.
- Subtraction: when CARRY=0 (borrow), S holds the ten's complement (e.g. 0001-0002 = 9999).
- Latency: START high at edge n → BUSY high in cycles n+1..n+DIGITS → DONE high in cycle n+DIGITS+1. Throughput is one operation per DIGITS+1 cycles.
- Outputs S, CARRY and INVALID hold between DONEs. A new START does not clear them until the next DONE entry.

Decomposition:
- Shared include file bcd_defs.vh:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - BCD_MAX=4'd9 and BCD_ADJ=4'd6.
- Sub-module bcd_digit_add: combinational one-digit adder.
  - Inputs: a[3:0], b[3:0], cin, sub.
  - Outputs: s[3:0], cout, bad (a>9 or b>9).
  - Instantiated once; the top holds the FSM, index counter, operand shift registers and output registers.

Test Plan:
1. DIGITS=4, add, X=16'h0099, Y=16'h0001, START at edge 0 → BUSY cycles 1-4; DONE at cycle 5 with S=16'h0100, CARRY=0, INVALID=0.
2. Add, X=16'h9999, Y=16'h0001 → S=16'h0000, CARRY=1. Add, X=16'h4567, Y=16'h5678 → S=16'h0245, CARRY=1.
3. SUB, X=16'h0100, Y=16'h0001 → S=16'h0099, CARRY=1. SUB, X=16'h0001, Y=16'h0002 → S=16'h9999, CARRY=0.
4. Add, X=16'h00A3, Y=16'h0005 → DONE with S=0, CARRY=0, INVALID=1. Next valid add of 0003+0005 → S=16'h0008, INVALID=0.
5. Handshake and reset:
   - START pulsed again during BUSY with different X/Y → ignored; result matches the first operands.
   - RST_N low at cycle 2 of RUN → all outputs 0 immediately, no DONE.
   - START held high across DONE → next operation begins with no idle cycle.
6. DIGITS=1: X=4'h9, Y=4'h9 → DONE at cycle 2 with S=4'h8, CARRY=1. SUB, X=4'h3, Y=4'h7 → S=4'h6, CARRY=0.
